// File: rtl/parking_occupancy_counter.sv
// parking_occupancy_counter
//   Samples one presence sensor per parking spot, synchronizes and debounces
//   each one, and produces registered occupied/vacant counts plus the 2-bit
//   digit scan index for the downstream 4-digit display multiplexer.
//
// Ports
//   clk      in   system clock, rising edge
//   reset_n  in   synchronous active-low reset
//   sensor   in   [SPOTS] per-spot presence, asynchronous, may bounce
//   free     out  [4] vacant spot count (registered)
//   busy     out  [4] occupied spot count (registered)
//   cont     out  [2] display scan index 0..3 (registered)
//   full     out  high while busy == SPOTS (registered)
//   changed  out  one-cycle pulse when busy/free take a new value
module parking_occupancy_counter #(
   parameter int unsigned SPOTS    = 8,
   parameter int unsigned DEBOUNCE = 4,
   parameter int unsigned SCAN_DIV = 50000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [SPOTS-1:0] sensor,
   output logic [3:0]       free,
   output logic [3:0]       busy,
   output logic [1:0]       cont,
   output logic             full,
   output logic             changed
);

   if (SPOTS < 1 || SPOTS > 15) begin : g_bad_spots
      $error("parking_occupancy_counter: SPOTS must be in 1..15");
   end
   if (DEBOUNCE < 1) begin : g_bad_debounce
      $error("parking_occupancy_counter: DEBOUNCE must be >= 1");
   end
   if (SCAN_DIV < 1) begin : g_bad_scan_div
      $error("parking_occupancy_counter: SCAN_DIV must be >= 1");
   end

   // Debounce counter only ever holds 0..DEBOUNCE-1.
   localparam int unsigned CntW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam int unsigned PreW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE - 1);
   localparam logic [PreW-1:0] PreMax = PreW'(SCAN_DIV - 1);
   localparam logic [3:0]      SpotsW = 4'(SPOTS);

   logic [SPOTS-1:0] sync1_d, sync1_q;
   logic [SPOTS-1:0] sync2_d, sync2_q;
   logic [SPOTS-1:0] stable_d, stable_q;
   logic [CntW-1:0]  cnt_d [SPOTS];
   logic [CntW-1:0]  cnt_q [SPOTS];
   logic [PreW-1:0]  pre_d, pre_q;
   logic [1:0]       cont_d, cont_q;
   logic [3:0]       busy_d, busy_q;
   logic [3:0]       free_d, free_q;
   logic             full_d, full_q;
   logic             changed_d, changed_q;

   always_comb begin
      sync1_d  = sensor;
      sync2_d  = sync1_q;
      stable_d = stable_q;
      for (int i = 0; i < int'(SPOTS); i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != stable_q[i]) begin
            // Accept the new level on the cycle the count would reach DEBOUNCE.
            if (cnt_q[i] == CntMax) begin
               stable_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end

      busy_d = '0;
      for (int i = 0; i < int'(SPOTS); i++) begin
         busy_d = busy_d + 4'(stable_q[i]);
      end
      free_d    = SpotsW - busy_d;
      full_d    = (busy_d == SpotsW);
      changed_d = (busy_d != busy_q);

      if (pre_q == PreMax) begin
         pre_d  = '0;
         cont_d = cont_q + 2'd1;
      end else begin
         pre_d  = pre_q + 1'b1;
         cont_d = cont_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         stable_q  <= '0;
         for (int i = 0; i < int'(SPOTS); i++) begin
            cnt_q[i] <= '0;
         end
         pre_q     <= '0;
         cont_q    <= '0;
         busy_q    <= '0;
         free_q    <= SpotsW;
         full_q    <= 1'b0;
         changed_q <= 1'b0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         stable_q  <= stable_d;
         for (int i = 0; i < int'(SPOTS); i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         pre_q     <= pre_d;
         cont_q    <= cont_d;
         busy_q    <= busy_d;
         free_q    <= free_d;
         full_q    <= full_d;
         changed_q <= changed_d;
      end
   end

   assign free    = free_q;
   assign busy    = busy_q;
   assign cont    = cont_q;
   assign full    = full_q;
   assign changed = changed_q;

endmodule
